// File: rtl/canny_seq_ctrl.sv
// Frame sequencer for the edge-detection datapath: counts load beats into the pixel
// buffer, then scans every 3x3 window centre once per stage with a drain gap between stages.
module canny_seq_ctrl #(
    parameter int IMG_W      = 20,
    parameter int IMG_H      = 20,
    parameter int PIX_PER_BT = 5,
    parameter int N_STAGES   = 4,
    parameter int STAGE_LAT  = 3,
    parameter int AW         = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_end,
    output logic          buf_wr_en,
    output logic [AW-1:0] buf_wr_row,
    output logic [AW-1:0] buf_wr_col,
    output logic [1:0]    stage_sel,
    output logic          win_valid,
    output logic [AW-1:0] win_row,
    output logic [AW-1:0] win_col,
    output logic          readable,
    output logic          done,
    output logic          load_err
);

    localparam int DW = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic                 wr_en_r, wr_en_s;
    logic [AW-1:0]        wr_row_r, wr_row_s;
    logic [AW-1:0]        wr_col_r, wr_col_s;
    logic [1:0]           stage_r, stage_s;
    logic                 win_vld_r, win_vld_s;
    logic [AW-1:0]        win_row_r, win_row_s;
    logic [AW-1:0]        win_col_r, win_col_s;
    logic [DW-1:0]        drain_cnt_r, drain_cnt_s;
    logic                 done_r, done_s;
    logic                 load_err_r, load_err_s;
    logic [STAGE_LAT-1:0] rd_sr_r;
    logic                 rd_in_s;
    logic                 last_beat_s;
    logic                 last_stage_s;

    assign last_beat_s  = (wr_row_r == AW'(IMG_H - 1)) && (wr_col_r == AW'(IMG_W - PIX_PER_BT));
    assign last_stage_s = (stage_r == 2'(N_STAGES - 1));
    // Only final-stage windows produce an edge_out worth reading.
    assign rd_in_s      = win_vld_r && last_stage_s;

    assign buf_wr_en  = wr_en_r;
    assign buf_wr_row = wr_row_r;
    assign buf_wr_col = wr_col_r;
    assign stage_sel  = stage_r;
    assign win_valid  = win_vld_r;
    assign win_row    = win_row_r;
    assign win_col    = win_col_r;
    assign readable   = rd_sr_r[STAGE_LAT-1];
    assign done       = done_r;
    assign load_err   = load_err_r;

    // Next-state and next-output decode; every output is taken from a flop.
    always_comb begin
        state_s     = state_r;
        wr_en_s     = wr_en_r;
        wr_row_s    = wr_row_r;
        wr_col_s    = wr_col_r;
        stage_s     = stage_r;
        win_vld_s   = win_vld_r;
        win_row_s   = win_row_r;
        win_col_s   = win_col_r;
        drain_cnt_s = drain_cnt_r;
        done_s      = done_r;
        load_err_s  = load_err_r;
        case (state_r)
            ST_LOAD: begin
                // The write strobe is low only in the first cycle after reset; beat 0 follows.
                if (!wr_en_r) begin
                    wr_en_s  = 1'b1;
                    wr_row_s = {AW{1'b0}};
                    wr_col_s = {AW{1'b0}};
                end else if (load_end || last_beat_s) begin
                    state_s   = ST_SCAN;
                    wr_en_s   = 1'b0;
                    wr_row_s  = {AW{1'b0}};
                    wr_col_s  = {AW{1'b0}};
                    win_vld_s = 1'b1;
                    win_row_s = AW'(1);
                    win_col_s = AW'(1);
                    if (!(load_end && last_beat_s)) begin
                        load_err_s = 1'b1;
                    end else begin
                        load_err_s = load_err_r;
                    end
                end else begin
                    wr_en_s = 1'b1;
                    if (wr_col_r == AW'(IMG_W - PIX_PER_BT)) begin
                        wr_col_s = {AW{1'b0}};
                        wr_row_s = wr_row_r + AW'(1);
                    end else begin
                        wr_col_s = wr_col_r + AW'(PIX_PER_BT);
                        wr_row_s = wr_row_r;
                    end
                end
            end
            ST_SCAN: begin
                if (win_col_r == AW'(IMG_W - 2)) begin
                    if (win_row_r == AW'(IMG_H - 2)) begin
                        state_s     = ST_DRAIN;
                        win_vld_s   = 1'b0;
                        win_row_s   = {AW{1'b0}};
                        win_col_s   = {AW{1'b0}};
                        drain_cnt_s = {DW{1'b0}};
                    end else begin
                        win_row_s = win_row_r + AW'(1);
                        win_col_s = AW'(1);
                    end
                end else begin
                    win_col_s = win_col_r + AW'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DW'(STAGE_LAT - 1)) begin
                    drain_cnt_s = {DW{1'b0}};
                    if (last_stage_s) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s   = ST_SCAN;
                        stage_s   = stage_r + 2'd1;
                        win_vld_s = 1'b1;
                        win_row_s = AW'(1);
                        win_col_s = AW'(1);
                    end
                end else begin
                    drain_cnt_s = drain_cnt_r + DW'(1);
                end
            end
            ST_DONE: begin
                done_s    = 1'b1;
                wr_en_s   = 1'b0;
                win_vld_s = 1'b0;
            end
            default: begin
                state_s = ST_LOAD;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_LOAD;
            wr_en_r     <= 1'b0;
            wr_row_r    <= {AW{1'b0}};
            wr_col_r    <= {AW{1'b0}};
            stage_r     <= 2'd0;
            win_vld_r   <= 1'b0;
            win_row_r   <= {AW{1'b0}};
            win_col_r   <= {AW{1'b0}};
            drain_cnt_r <= {DW{1'b0}};
            done_r      <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            wr_en_r     <= wr_en_s;
            wr_row_r    <= wr_row_s;
            wr_col_r    <= wr_col_s;
            stage_r     <= stage_s;
            win_vld_r   <= win_vld_s;
            win_row_r   <= win_row_s;
            win_col_r   <= win_col_s;
            drain_cnt_r <= drain_cnt_s;
            done_r      <= done_s;
            load_err_r  <= load_err_s;
        end
    end

    // Delay line matching the datapath latency from window issue to result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_sr_r <= {STAGE_LAT{1'b0}};
        end else begin
            rd_sr_r[0] <= rd_in_s;
            for (int i = 1; i < STAGE_LAT; i++) begin
                rd_sr_r[i] <= rd_sr_r[i-1];
            end
        end
    end

endmodule

// File: tb/tb_canny_seq_ctrl.sv
// Directed bench for canny_seq_ctrl: nominal, early and missing load_end, window order,
// mid-frame reset and post-done hold, all against hand-computed cycle numbers.
module tb_canny_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       load_end;
    logic       buf_wr_en;
    logic [4:0] buf_wr_row;
    logic [4:0] buf_wr_col;
    logic [1:0] stage_sel;
    logic       win_valid;
    logic [4:0] win_row;
    logic [4:0] win_col;
    logic       readable;
    logic       done;
    logic       load_err;

    int n_checks = 0;
    int n_bad    = 0;

    canny_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .load_end   (load_end),
        .buf_wr_en  (buf_wr_en),
        .buf_wr_row (buf_wr_row),
        .buf_wr_col (buf_wr_col),
        .stage_sel  (stage_sel),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .readable   (readable),
        .done       (done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outs_vec();
        return int'({buf_wr_en, buf_wr_row, buf_wr_col, stage_sel, win_valid,
                     win_row, win_col, readable, done, load_err});
    endfunction

    // Hold reset for two cycles, check all outputs are low, release on a falling edge.
    task automatic apply_reset(input string nm);
        load_end = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val({nm, "_rst_outs"}, outs_vec(), 0);
        reset = 1'b1;
    endtask

    // Run one frame from cycle 0, pulsing load_end on le_beat (-1 = never).
    task automatic run_frame(input string nm, input int le_beat, input int exp_writes,
                             input int exp_lrow, input int exp_lcol, input int exp_scan,
                             input int exp_rd_first, input int exp_done, input int exp_err);
        int writes = 0, lrow = -1, lcol = -1, wr_bad = 0;
        int first_scan = -1, n_win = 0, order_bad = 0, gap_bad = 0, stage_bad = 0;
        int gap = 0, seen_valid = 0, prev_valid = 0, prev_rd = 0, prev_stage = 0;
        int m_stage = 0, m_row = 1, m_col = 1;
        int rd_first = -1, rd_last = -1, rd_cnt = 0, done_first = -1;
        for (int cyc = 0; cyc < 1400; cyc++) begin
            @(negedge clk);
            load_end = (cyc == le_beat);
            if (buf_wr_en) begin
                if (buf_wr_row != 5'(writes / 4) || buf_wr_col != 5'(5 * (writes % 4)))
                    wr_bad++;
                writes++;
                lrow = buf_wr_row;
                lcol = buf_wr_col;
            end
            if (int'(stage_sel) != prev_stage) begin
                if (prev_valid != 0 || prev_rd != 0 || int'(stage_sel) != prev_stage + 1)
                    stage_bad++;
            end
            if (win_valid) begin
                if (first_scan < 0) first_scan = cyc;
                if (seen_valid != 0 && prev_valid == 0 && gap != 3) gap_bad++;
                if (int'(stage_sel) != m_stage || int'(win_row) != m_row || int'(win_col) != m_col)
                    order_bad++;
                m_col++;
                if (m_col > 18) begin
                    m_col = 1;
                    m_row++;
                    if (m_row > 18) begin
                        m_row = 1;
                        m_stage++;
                    end
                end
                n_win++;
                gap = 0;
                seen_valid = 1;
            end else if (seen_valid != 0) begin
                gap++;
            end
            if (readable) begin
                if (rd_first < 0) rd_first = cyc;
                rd_last = cyc;
                rd_cnt++;
            end
            if (done && done_first < 0) done_first = cyc;
            prev_valid = int'(win_valid);
            prev_rd    = int'(readable);
            prev_stage = int'(stage_sel);
        end
        load_end = 1'b0;
        check_val({nm, "_writes"}, writes, exp_writes);
        check_val({nm, "_last_row"}, lrow, exp_lrow);
        check_val({nm, "_last_col"}, lcol, exp_lcol);
        check_val({nm, "_wr_order"}, wr_bad, 0);
        check_val({nm, "_scan_start"}, first_scan, exp_scan);
        check_val({nm, "_n_windows"}, n_win, 1296);
        check_val({nm, "_win_order"}, order_bad, 0);
        check_val({nm, "_drain_gap"}, gap_bad, 0);
        check_val({nm, "_stage_step"}, stage_bad, 0);
        check_val({nm, "_rd_first"}, rd_first, exp_rd_first);
        check_val({nm, "_rd_count"}, rd_cnt, 324);
        check_val({nm, "_rd_contig"}, rd_last - rd_first + 1, 324);
        check_val({nm, "_done_cycle"}, done_first, exp_done);
        check_val({nm, "_load_err"}, int'(load_err), exp_err);
        check_val({nm, "_final_stage"}, int'(stage_sel), 3);
    endtask

    initial begin
        int hold_bad;
        reset    = 1'b0;
        load_end = 1'b0;

        // Nominal frame with load_end on the last beat.
        apply_reset("nom");
        run_frame("nom", 79, 80, 19, 15, 80, 1064, 1388, 0);

        // Post-done hold with stray load_end pulses.
        hold_bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            load_end = ((i % 97) == 5);
            if (!done || buf_wr_en || win_valid || readable || stage_sel != 2'd3)
                hold_bad++;
        end
        load_end = 1'b0;
        check_val("hold_violations", hold_bad, 0);
        check_val("hold_load_err", int'(load_err), 0);

        // Early load_end on beat 40 (row 10, col 0).
        apply_reset("early");
        run_frame("early", 40, 41, 10, 0, 41, 1025, 1349, 1);

        // load_end never asserted.
        apply_reset("noend");
        run_frame("noend", -1, 80, 19, 15, 80, 1064, 1388, 1);

        // Reset pulsed during stage 1 scan (early load_end so load_err is set).
        apply_reset("mid");
        for (int cyc = 0; cyc <= 500; cyc++) begin
            @(negedge clk);
            load_end = (cyc == 40);
        end
        load_end = 1'b0;
        check_val("mid_pre_valid", int'(win_valid), 1);
        check_val("mid_pre_stage", int'(stage_sel), 1);
        check_val("mid_pre_row", int'(win_row), 8);
        check_val("mid_pre_col", int'(win_col), 7);
        check_val("mid_pre_err", int'(load_err), 1);
        reset = 1'b0;
        #1;
        check_val("mid_async_outs", outs_vec(), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_rel_wr_en", int'(buf_wr_en), 1);
        check_val("mid_rel_row", int'(buf_wr_row), 0);
        check_val("mid_rel_col", int'(buf_wr_col), 0);
        check_val("mid_rel_valid", int'(win_valid), 0);
        check_val("mid_rel_done", int'(done), 0);
        check_val("mid_rel_err", int'(load_err), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
